// File: rtl/corefifo_gray_bin_pipe.sv
// corefifo_gray_bin_pipe
//   Pipelined gray <-> binary converter for FIFO pointer paths. NUM_CH
//   independent lanes of W = ADDRWIDTH+1 bits travel together through
//   PIPE_STAGES register stages under a valid/ready handshake.
//   MODE 0: gray-to-binary. The MSB-first XOR chain is split so that each
//           stage resolves ceil(W/PIPE_STAGES) bits. A stage register holds
//           already-resolved binary bits on top and raw gray bits below.
//   MODE 1: binary-to-gray. This is computed in stage 1, and the remaining
//           stages only add delay.
//
// Optional feature macro: COREFIFO_GRAY_CHK_EN
//   When defined, a per-lane checker flags (sticky) any accepted gray-side
//   value that differs from the previous accepted one in more than one bit.
//   When undefined, gray_err is tied to 0.
//
// Ports
//   CLK        in   clock, rising edge
//   RESET      in   synchronous, active-high reset
//   in_valid   in   input transfer valid
//   in_ready   out  stage 1 can load (never depends on in_valid)
//   in_data    in   NUM_CH*W, lane c at [c*W +: W]
//   out_valid  out  last stage holds a result
//   out_ready  in   downstream accepts the result
//   out_data   out  converted lanes, same packing as in_data
//   gray_err   out  NUM_CH sticky gray-sequence error flags
module corefifo_gray_bin_pipe #(
    parameter int ADDRWIDTH   = 3,
    parameter int NUM_CH      = 1,
    parameter int PIPE_STAGES = 1,
    parameter int MODE        = 0
) (
    input  logic                                CLK,
    input  logic                                RESET,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NUM_CH*(ADDRWIDTH+1)-1:0]     in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NUM_CH*(ADDRWIDTH+1)-1:0]     out_data,
    output logic [NUM_CH-1:0]                   gray_err
);

    localparam int W   = ADDRWIDTH + 1;
    localparam int DW  = NUM_CH * W;
    localparam int BPS = (PIPE_STAGES < 1) ? W : (W + PIPE_STAGES - 1) / PIPE_STAGES;

    if (PIPE_STAGES < 1 || PIPE_STAGES > W) begin : g_bad_pipe_stages
        $error("corefifo_gray_bin_pipe: PIPE_STAGES must be within 1..ADDRWIDTH+1");
    end
    if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
        $error("corefifo_gray_bin_pipe: NUM_CH must be within 1..8");
    end

    // Resolve gray bits lo..hi into binary. The bit directly above hi is
    // either the MSB (binary MSB equals gray MSB) or was resolved by an
    // earlier stage, so the chain can simply continue from it.
    function automatic logic [W-1:0] f_g2b_part(input logic [W-1:0] x,
                                                input int lo,
                                                input int hi);
        logic [W-1:0] y;
        y = x;
        for (int i = W - 2; i >= 0; i--) begin
            if (i >= lo && i <= hi) begin
                y[i] = y[i+1] ^ x[i];
            end
        end
        return y;
    endfunction

    function automatic logic [W-1:0] f_b2g(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [PIPE_STAGES-1:0] r_valid;
    logic [DW-1:0]          r_data [PIPE_STAGES];

    logic [PIPE_STAGES-1:0] w_load;
    logic [PIPE_STAGES-1:0] w_up_valid;
    logic [DW-1:0]          w_up_data [PIPE_STAGES];
    logic [DW-1:0]          w_next    [PIPE_STAGES];

    always_comb begin : c_pipe
        logic w_room;
        int   lo;
        int   hi;
        w_room = out_ready;
        w_load = '0;
        lo     = 0;
        hi     = 0;

        w_up_valid[0] = in_valid;
        w_up_data[0]  = in_data;
        for (int s = 1; s < PIPE_STAGES; s++) begin
            w_up_valid[s] = r_valid[s-1];
            w_up_data[s]  = r_data[s-1];
        end

        // A stage may load if it, or any stage downstream of it, is empty,
        // or if the output is being taken this cycle. Walking from the
        // output end keeps this a simple OR chain with no loop.
        for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
            w_room    = w_room | ~r_valid[s];
            w_load[s] = w_room;
        end

        for (int s = 0; s < PIPE_STAGES; s++) begin
            w_next[s] = w_up_data[s];
            hi = W - 1 - s * BPS;
            lo = W - (s + 1) * BPS;
            if (lo < 0) begin
                lo = 0;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (MODE == 0) begin
                    w_next[s][c*W +: W] = f_g2b_part(w_up_data[s][c*W +: W], lo, hi);
                end else if (s == 0) begin
                    w_next[s][c*W +: W] = f_b2g(w_up_data[s][c*W +: W]);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_valid <= '0;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                r_data[s] <= '0;
            end
        end else begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                if (w_load[s]) begin
                    r_valid[s] <= w_up_valid[s];
                    // Data only moves with a valid entry, which keeps the
                    // output register quiet between transfers.
                    if (w_up_valid[s]) begin
                        r_data[s] <= w_next[s];
                    end
                end
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_valid[PIPE_STAGES-1];
    assign out_data  = r_data[PIPE_STAGES-1];

`ifdef COREFIFO_GRAY_CHK_EN
    logic [DW-1:0]     w_gray_side;
    logic [NUM_CH-1:0] w_multi;
    logic [DW-1:0]     r_last;
    logic [NUM_CH-1:0] r_seen;
    logic [NUM_CH-1:0] r_err;

    // In MODE 1 the gray-side value is the freshly encoded stage-1 result.
    assign w_gray_side = (MODE == 0) ? in_data : w_next[0];

    always_comb begin : c_gray_chk
        logic [W-1:0] w_diff;
        w_diff  = '0;
        w_multi = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_diff     = r_last[c*W +: W] ^ w_gray_side[c*W +: W];
            // More than one bit set: clearing the lowest set bit leaves
            // something behind.
            w_multi[c] = (w_diff & (w_diff - W'(1))) != '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_last <= '0;
            r_seen <= '0;
            r_err  <= '0;
        end else if (in_valid && w_load[0]) begin
            r_last <= w_gray_side;
            r_seen <= '1;
            r_err  <= r_err | (r_seen & w_multi);
        end
    end

    assign gray_err = r_err;
`else
    assign gray_err = '0;
`endif

endmodule
